cp0: RTL and testbench

Coprocessor-0 block for the pipelined MIPS core: the consuming end of the device interrupt lines raised by the timers and other peripherals. It holds SR, Cause, EPC and PrID. It merges the six hardware interrupt lines with the synchronous exception code from the pipeline's commit stage and raises a single request that flushes the pipeline and redirects fetch to the handler. It also serves mfc0/mtc0 accesses and eret.

---
 rtl/cp0_if.sv | 25 ++
 rtl/cp0.sv | 88 ++++++++
 tb/tb_cp0.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cp0_if.sv
// Pipeline-to-CP0 bus: register access, commit-stage exception info,
// interrupt lines, and the request/EPC outputs back to the pipeline.
interface cp0_if;
    logic [4:0]  addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output addr, we, wd, vpc, bd_in, exc_code, hw_int, exl_clr,
        input  rd, req, epc_out
    );

    modport slave (
        input  addr, we, wd, vpc, bd_in, exc_code, hw_int, exl_clr,
        output rd, req, epc_out
    );
endinterface

// File: rtl/cp0.sv
// Coprocessor 0: SR/Cause/EPC/PrID, interrupt/exception request merge,
// mfc0/mtc0 access and eret handling.
module cp0 #(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);
    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exccode;
    logic [29:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [29:0] w_epc_cap;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_epc;

    assign w_int_req = (|(bus.hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (bus.exc_code != 5'd0) & ~r_exl;
    assign w_req     = (w_int_req | w_exc_req) & ~reset;

    // Word-granular EPC: subtracting one word from vpc[31:2] equals (vpc-4)>>2, wrapping naturally.
    assign w_epc_cap = bus.bd_in ? (bus.vpc[31:2] - 30'd1) : bus.vpc[31:2];

    assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exccode, 2'b00};
    assign w_epc   = {r_epc, 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_im      <= '0;
            r_exl     <= 1'b0;
            r_ie      <= 1'b0;
            r_bd      <= 1'b0;
            r_ip      <= '0;
            r_exccode <= '0;
            r_epc     <= '0;
        end else begin
            r_ip <= bus.hw_int;
            // A flushed mtc0/eret that collides with a taken request must not commit.
            if (w_req) begin
                r_exl     <= 1'b1;
                r_bd      <= bus.bd_in;
                r_exccode <= w_int_req ? 5'd0 : bus.exc_code;
                r_epc     <= w_epc_cap;
            end else if (bus.exl_clr) begin
                r_exl <= 1'b0;
            end else if (bus.we) begin
                case (bus.addr)
                    A_SR: begin
                        r_im  <= bus.wd[15:10];
                        r_exl <= bus.wd[1];
                        r_ie  <= bus.wd[0];
                    end
                    A_EPC:   r_epc <= bus.wd[31:2];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        bus.rd = 32'd0;
        case (bus.addr)
            A_SR:    bus.rd = w_sr;
            A_CAUSE: bus.rd = w_cause;
            A_EPC:   bus.rd = w_epc;
            A_PRID:  bus.rd = PRID;
            default: bus.rd = 32'd0;
        endcase
    end

    assign bus.req     = w_req;
    assign bus.epc_out = w_epc;
endmodule

// File: tb/tb_cp0.sv
// Self-checking bench for cp0: directed scenarios plus randomized traffic
// compared against a register-level reference model.
module tb_cp0;
    localparam logic [31:0] PRID = 32'h4D49_5053;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [31:0] m_sr, m_cause, m_epc;

    cp0_if bus ();

    cp0 #(.PRID(PRID)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_int();
        return (|(bus.hw_int & m_sr[15:10])) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        logic exc;
        exc = (bus.exc_code != 5'd0) && !m_sr[1];
        return (model_int() || exc) && !reset;
    endfunction

    // Check outputs against the model, then advance one clock and update the model.
    task automatic cycle();
        logic [31:0] tgt;
        #1;
        chk("req", {31'd0, bus.req}, {31'd0, model_req()});
        chk("epc_out", bus.epc_out, m_epc);
        chk("rd", bus.rd, model_rd(bus.addr));
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            if (model_req()) begin
                m_cause[31]  = bus.bd_in;
                m_cause[6:2] = model_int() ? 5'd0 : bus.exc_code;
                tgt = bus.bd_in ? bus.vpc - 32'd4 : bus.vpc;
                m_epc = tgt & 32'hFFFF_FFFC;
                m_sr[1] = 1'b1;
            end else if (bus.exl_clr) begin
                m_sr[1] = 1'b0;
            end else if (bus.we) begin
                if (bus.addr == 5'd12) m_sr = bus.wd & 32'h0000_FC03;
                else if (bus.addr == 5'd14) m_epc = bus.wd & 32'hFFFF_FFFC;
            end
            m_cause[15:10] = bus.hw_int;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rdchk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rd, exp);
    endtask

    task automatic idle();
        bus.we = 0; bus.exl_clr = 0; bus.exc_code = 0; bus.bd_in = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.addr = a; bus.wd = d; bus.we = 1;
        cycle();
        bus.we = 0;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_sr = 0; m_cause = 0; m_epc = 0;
        bus.addr = 0; bus.wd = 0; bus.vpc = 0; bus.hw_int = 6'h3F;
        idle();
        reset = 1;
        @(posedge clk); #1;
        cycle();
        chk("req_in_reset", {31'd0, bus.req}, 32'd0);
        cycle();
        reset = 0;
        rdchk("rst_sr", 5'd12, 32'd0);
        rdchk("rst_cause", 5'd13, 32'd0);
        rdchk("rst_epc", 5'd14, 32'd0);
        rdchk("rst_prid", 5'd15, PRID);
        chk("rst_req", {31'd0, bus.req}, 32'd0);

        // Interrupt taken
        bus.hw_int = 0;
        wr(5'd12, 32'h0000_0401);
        bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3010; bus.bd_in = 0;
        #1 chk("int_req", {31'd0, bus.req}, 32'd1);
        cycle();
        rdchk("int_sr", 5'd12, 32'h0000_0403);
        rdchk("int_cause", 5'd13, 32'h0000_0400);
        rdchk("int_epc", 5'd14, 32'h0000_3010);
        chk("int_req_after", {31'd0, bus.req}, 32'd0);
        cycle();

        // Delay slot plus interrupt-over-exception priority
        bus.hw_int = 0;
        wr(5'd12, 32'h0000_FC01);
        bus.hw_int = 6'b000010; bus.exc_code = 5'd10; bus.bd_in = 1; bus.vpc = 32'h0000_3004;
        #1 chk("ds_req", {31'd0, bus.req}, 32'd1);
        cycle();
        idle();
        rdchk("ds_cause", 5'd13, 32'h8000_0800);
        rdchk("ds_epc", 5'd14, 32'h0000_3000);

        // Exception with IE=0
        bus.hw_int = 0;
        wr(5'd12, 32'h0000_0000);
        bus.exc_code = 5'd4; bus.vpc = 32'h0000_3020;
        #1 chk("exc_req", {31'd0, bus.req}, 32'd1);
        cycle();
        idle();
        bus.addr = 5'd13; #1;
        chk("exc_code", {27'd0, bus.rd[6:2]}, 32'd4);
        rdchk("exc_epc", 5'd14, 32'h0000_3020);

        // eret and level re-request
        bus.hw_int = 6'b000001;
        wr(5'd12, 32'h0000_0403);
        #1 chk("eret_pre_req", {31'd0, bus.req}, 32'd0);
        bus.exl_clr = 1;
        cycle();
        bus.exl_clr = 0;
        rdchk("eret_sr", 5'd12, 32'h0000_0401);
        chk("eret_req", {31'd0, bus.req}, 32'd1);
        bus.vpc = 32'h0000_3030;
        cycle();

        // Collisions
        bus.hw_int = 0;
        wr(5'd12, 32'h0000_0401);
        bus.hw_int = 6'b000001; bus.vpc = 32'h0000_3040;
        wr(5'd14, 32'h1234_5677);
        rdchk("col_epc", 5'd14, 32'h0000_3040);
        bus.hw_int = 0;
        wr(5'd12, 32'h0000_0000);
        wr(5'd14, 32'h1234_5677);
        rdchk("wr_epc", 5'd14, 32'h1234_5674);
        wr(5'd13, 32'hFFFF_FFFF);
        rdchk("wr_cause", 5'd13, m_cause);

        // vpc-4 wraps at zero
        bus.exc_code = 5'd1; bus.bd_in = 1; bus.vpc = 32'h0000_0000;
        cycle();
        idle();
        rdchk("wrap_epc", 5'd14, 32'hFFFF_FFFC);
        wr(5'd12, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 31) == 0);
            bus.addr     = ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'(12 + $urandom_range(0, 3));
            bus.we       = ($urandom_range(0, 3) == 0);
            bus.wd       = $urandom();
            bus.exl_clr  = ($urandom_range(0, 5) == 0);
            bus.exc_code = ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'd0;
            bus.hw_int   = ($urandom_range(0, 1) == 0) ? 6'($urandom()) : 6'd0;
            bus.bd_in    = 1'($urandom());
            bus.vpc      = ($urandom_range(0, 15) == 0) ? 32'd0 : ($urandom() & 32'hFFFF_FFFC);
            cycle();
        end
        reset = 0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
